// File: rtl/layer_5_maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool for one FP32 channel in raster order.
// The top row of each window is folded into a half-width line buffer; the bottom row completes it.
module layer_5_maxpool_2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 104
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  last_out
);

    localparam int HALF = IMG_SIZE / 2;
    localparam int CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 2;

    generate
        if ((IMG_SIZE % 2) != 0 || IMG_SIZE < 2) begin : g_bad_size
            $error("layer_5_maxpool_2x2: IMG_SIZE must be even and at least 2");
        end
    endgenerate

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] linebuf [HALF];
    logic [CW-2:0]         lb_idx;
    logic                  col_last;
    logic                  row_last;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] win_max;

    // Maps an IEEE-754 pattern to an unsigned key whose ordering matches the float ordering.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x | {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    // Equal keys keep the first operand, so the result is always one input's exact pattern.
    function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        return (order_key(b) > order_key(a)) ? b : a;
    endfunction

    assign lb_idx   = col[CW-1:1];
    assign col_last = (col == CW'(IMG_SIZE - 1));
    assign row_last = (row == CW'(IMG_SIZE - 1));
    assign pair_max = fp_max(hold, data_in);
    assign win_max  = fp_max(linebuf[lb_idx], pair_max);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (valid_in) begin
                if (!col[0]) begin
                    hold <= data_in;
                end else if (row[0]) begin
                    data_out  <= win_max;
                    valid_out <= 1'b1;
                    last_out  <= row_last && col_last;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (valid_in && col[0] && !row[0]) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

endmodule

// File: tb/tb_layer_5_maxpool_2x2.sv
// Scoreboard bench for layer_5_maxpool_2x2: a 4x4 instance for directed frames and a default
// 104x104 instance for random frames, both checked against a window-max reference model.
module tb_layer_5_maxpool_2x2;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [31:0] cyc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] din4 = '0, din104 = '0;
    logic        vin4 = 1'b0, vin104 = 1'b0;
    logic [31:0] dout4, dout104;
    logic        vout4, vout104, last4, last104;

    always #5 Clk = ~Clk;

    layer_5_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .data_in(din4), .valid_in(vin4),
        .data_out(dout4), .valid_out(vout4), .last_out(last4)
    );

    layer_5_maxpool_2x2 dut104 (
        .Clk(Clk), .Rst(Rst), .data_in(din104), .valid_in(vin104),
        .data_out(dout104), .valid_out(vout104), .last_out(last104)
    );

    logic [31:0] img [0:103][0:103];
    int          n_sz = 4;
    int          r = 0, c = 0;
    bit          sel104 = 1'b0;
    int          cyc = 0;
    bit          stim_done = 1'b0;
    int          checks = 0, failures = 0;
    int          pulses104 = 0, lasts104 = 0;
    exp_t        q4[$];
    exp_t        q104[$];

    logic [31:0] ramp_exp [4] = '{32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000};
    logic [31:0] neg_exp  [4] = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};

    always @(posedge Clk) cyc <= cyc + 1;

    // Float ordering: larger real value wins; -0 below +0; NaNs ranked by their raw bits.
    function automatic bit fp_greater(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka, kb;
        ka = a[31] ? ~a : {1'b1, a[30:0]};
        kb = b[31] ? ~b : {1'b1, b[30:0]};
        return ka > kb;
    endfunction

    function automatic logic [31:0] pool_ref(input int wr, input int wc);
        logic [31:0] v [4];
        logic [31:0] best;
        v[0] = img[wr][wc];
        v[1] = img[wr][wc+1];
        v[2] = img[wr+1][wc];
        v[3] = img[wr+1][wc+1];
        best = v[0];
        for (int i = 1; i < 4; i++) if (fp_greater(v[i], best)) best = v[i];
        return best;
    endfunction

    function automatic logic [31:0] to_f32(input int n);
        real         rv;
        logic [63:0] d;
        logic [10:0] e;
        if (n == 0) return 32'h0;
        rv = n;
        d  = $realtobits(rv);
        e  = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] d);
        @(posedge Clk);
        #1;
        if (sel104) begin
            vin104 = v; din104 = d; vin4 = 1'b0;
        end else begin
            vin4 = v; din4 = d; vin104 = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] px, input int gap, input bit push,
                        input bit use_ov, input logic [31:0] ov);
        exp_t e;
        repeat (gap) drive(1'b0, $urandom);
        drive(1'b1, px);
        img[r][c] = px;
        if ((r % 2 == 1) && (c % 2 == 1) && push) begin
            e.d    = use_ov ? ov : pool_ref(r - 1, c - 1);
            e.last = (r == n_sz - 1) && (c == n_sz - 1);
            e.cyc  = cyc + 1;
            if (sel104) q104.push_back(e);
            else        q4.push_back(e);
        end
        c++;
        if (c == n_sz) begin
            c = 0;
            r++;
            if (r == n_sz) r = 0;
        end
    endtask

    task automatic ramp_frame(input bit neg, input int maxgap);
        int k;
        for (int p = 0; p < 16; p++) begin
            k = (r / 2) * 2 + (c / 2);
            send(neg ? to_f32(-(p + 1)) : to_f32(p),
                 (maxgap > 0) ? $urandom_range(0, maxgap) : 0,
                 1'b1, 1'b1, neg ? neg_exp[k] : ramp_exp[k]);
        end
    endtask

    // Stimulus
    initial begin
        logic [31:0] special [16];
        int k;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;

        ramp_frame(1'b0, 0);
        ramp_frame(1'b1, 0);

        special = '{32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                    32'h80000000, 32'h80000000, 32'h3F800000, 32'h3F800000,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int p = 8; p < 16; p++) special[p] = $urandom;
        for (int p = 0; p < 16; p++) begin
            k = (r / 2) * 2 + (c / 2);
            send(special[p], 0, 1'b1, (k < 2), (k == 0) ? 32'h00000000 : 32'h3F800000);
        end

        ramp_frame(1'b0, 5);
        drive(1'b0, 32'h0);

        // Six pixels of a frame; the pulse from pixel 5 is cancelled by reset.
        for (int p = 0; p < 6; p++) send(to_f32(p), 0, (p != 5), 1'b1, ramp_exp[0]);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        vin4 = 1'b0;
        r = 0;
        c = 0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        ramp_frame(1'b0, 0);
        drive(1'b0, 32'h0);

        sel104 = 1'b1;
        n_sz = 104;
        r = 0;
        c = 0;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 104 * 104; p++) send($urandom, 0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0);
        repeat (5) drive(1'b0, 32'h0);
        stim_done = 1'b1;
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                check("rst_data4", dout4, 32'h0);
                check("rst_valid4", {31'h0, vout4}, 32'h0);
                check("rst_last4", {31'h0, last4}, 32'h0);
                check("rst_data104", dout104, 32'h0);
                check("rst_valid104", {31'h0, vout104}, 32'h0);
                check("rst_last104", {31'h0, last104}, 32'h0);
            end else begin
                if (vout4) begin
                    if (q4.size() == 0) begin
                        check("unexpected_pulse4", dout4, 32'hxxxxxxxx);
                    end else begin
                        e = q4.pop_front();
                        check("data4", dout4, e.d);
                        check("last4", {31'h0, last4}, {31'h0, e.last});
                        check("latency4", cyc, e.cyc);
                    end
                end else begin
                    check("last4_idle", {31'h0, last4}, 32'h0);
                end
                if (vout104) begin
                    pulses104++;
                    if (last104) lasts104++;
                    if (q104.size() == 0) begin
                        check("unexpected_pulse104", dout104, 32'hxxxxxxxx);
                    end else begin
                        e = q104.pop_front();
                        check("data104", dout104, e.d);
                        check("last104", {31'h0, last104}, {31'h0, e.last});
                        check("latency104", cyc, e.cyc);
                    end
                end else begin
                    check("last104_idle", {31'h0, last104}, 32'h0);
                end
            end
            if (stim_done || cyc > 80000) begin
                if (!stim_done) check("timeout", 32'(cyc), 32'd80000);
                check("pending4", 32'(q4.size()), 32'd0);
                check("pending104", 32'(q104.size()), 32'd0);
                check("pulses104", 32'(pulses104), 32'd5408);
                check("lasts104", 32'(lasts104), 32'd2);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule
